raggedstone_spinn_aer_if_mode_sel: RTL and testbench

//  Consumes the debounced, active-low push-button level from the debouncer and

---
 rtl/raggedstone_spinn_aer_if_mode_sel.sv | 161 ++++++++++++++++
 tb/tb_raggedstone_spinn_aer_if_mode_sel.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/raggedstone_spinn_aer_if_mode_sel.sv
// raggedstone_spinn_aer_if_mode_sel
//
// Takes the debounced, active-low push-button level and classifies each press
// as short or long. A short press steps the interface operating mode, wrapping
// after the last mode. A long press restores the default mode. After every
// mode write the status LED blinks (mode+1) times.
//
// Ports
//   clk           in   1          system clock
//   rst           in   1          asynchronous, active-high reset
//   pb_debounced  in   1          debounced button level, 0 = pressed, idles 1
//   mode          out  MODE_BITS  current operating mode
//   mode_chg      out  1          one-cycle pulse whenever mode is written
//   long_press    out  1          one-cycle pulse when a press becomes long
//   led           out  1          status LED, 1 = on
module raggedstone_spinn_aer_if_mode_sel #(
    parameter int          NUM_MODES    = 4,
    parameter int          MODE_BITS    = 2,
    parameter int          DEFAULT_MODE = 0,
    parameter logic [23:0] LONG_CYCLES  = 24'd5000000,
    parameter logic [23:0] BLINK_HALF   = 24'd2500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pb_debounced,
    output logic [MODE_BITS-1:0] mode,
    output logic                 mode_chg,
    output logic                 long_press,
    output logic                 led
);

    localparam int                   BW         = MODE_BITS + 1;
    localparam logic [MODE_BITS-1:0] LAST_MODE  = MODE_BITS'(NUM_MODES - 1);
    localparam logic [MODE_BITS-1:0] DEF_MODE   = MODE_BITS'(DEFAULT_MODE);
    localparam logic [23:0]          LONG_LAST  = LONG_CYCLES - 24'd1;
    localparam logic [23:0]          BLINK_LAST = BLINK_HALF - 24'd1;

    typedef enum logic [1:0] {WAIT_REL, IDLE, PRESSED} press_state_t;
    typedef enum logic [1:0] {L_IDLE, L_ON, L_OFF}     led_state_t;

    // Hold counter never wraps back to zero, so an absurdly long hold can
    // never look like a fresh short press.
    function automatic logic [23:0] sat_inc24(input logic [23:0] v);
        return (v == 24'hFF_FFFF) ? v : v + 24'd1;
    endfunction

    press_state_t         p_state, p_state_n;
    logic [23:0]          hcnt, hcnt_n;
    logic [MODE_BITS-1:0] mode_n;
    logic                 mode_chg_n, long_press_n;

    led_state_t           l_state, l_state_n;
    logic [23:0]          tcnt, tcnt_n;
    logic [BW-1:0]        bcnt, bcnt_n;

    // Press classifier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state    <= WAIT_REL;
            hcnt       <= '0;
            mode       <= DEF_MODE;
            mode_chg   <= 1'b0;
            long_press <= 1'b0;
        end else begin
            p_state    <= p_state_n;
            hcnt       <= hcnt_n;
            mode       <= mode_n;
            mode_chg   <= mode_chg_n;
            long_press <= long_press_n;
        end
    end

    always_comb begin
        p_state_n    = p_state;
        hcnt_n       = hcnt;
        mode_n       = mode;
        mode_chg_n   = 1'b0;
        long_press_n = 1'b0;
        case (p_state)
            // Starting here out of reset means a button held across reset
            // release is ignored until it has been let go.
            WAIT_REL: begin
                if (pb_debounced) p_state_n = IDLE;
            end
            IDLE: begin
                if (!pb_debounced) begin
                    hcnt_n    = '0;
                    p_state_n = PRESSED;
                end
            end
            PRESSED: begin
                // Release is checked first: letting go on the threshold cycle
                // still counts as a short press.
                if (pb_debounced) begin
                    mode_n     = (mode == LAST_MODE) ? '0 : mode + 1'b1;
                    mode_chg_n = 1'b1;
                    p_state_n  = IDLE;
                end else if (hcnt == LONG_LAST) begin
                    mode_n       = DEF_MODE;
                    mode_chg_n   = 1'b1;
                    long_press_n = 1'b1;
                    p_state_n    = WAIT_REL;
                end else begin
                    hcnt_n = sat_inc24(hcnt);
                end
            end
            default: p_state_n = WAIT_REL;
        endcase
    end

    // Blink sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_state <= L_IDLE;
            tcnt    <= '0;
            bcnt    <= '0;
        end else begin
            l_state <= l_state_n;
            tcnt    <= tcnt_n;
            bcnt    <= bcnt_n;
        end
    end

    always_comb begin
        l_state_n = l_state;
        tcnt_n    = tcnt;
        bcnt_n    = bcnt;
        // mode already holds the new value in the cycle mode_chg is high.
        if (mode_chg) begin
            l_state_n = L_ON;
            tcnt_n    = '0;
            bcnt_n    = BW'(mode) + BW'(1);
        end else begin
            case (l_state)
                L_IDLE: ;
                L_ON: begin
                    if (tcnt == BLINK_LAST) begin
                        tcnt_n    = '0;
                        l_state_n = L_OFF;
                    end else begin
                        tcnt_n = tcnt + 24'd1;
                    end
                end
                L_OFF: begin
                    if (tcnt == BLINK_LAST) begin
                        tcnt_n    = '0;
                        bcnt_n    = bcnt - BW'(1);
                        l_state_n = (bcnt <= BW'(1)) ? L_IDLE : L_ON;
                    end else begin
                        tcnt_n = tcnt + 24'd1;
                    end
                end
                default: l_state_n = L_IDLE;
            endcase
        end
    end

    // Decoded straight from state so the async reset darkens the LED at once.
    assign led = (l_state == L_ON);

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_mode_sel.sv
module tb_raggedstone_spinn_aer_if_mode_sel;

    logic       clk;
    logic       rst;
    logic       pb_debounced;
    logic [1:0] mode;
    logic       mode_chg;
    logic       long_press;
    logic       led;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_chg, cnt_long, cnt_led, cnt_blink;
    logic led_prev;
    int long_at, chg_at;

    raggedstone_spinn_aer_if_mode_sel #(
        .NUM_MODES   (3),
        .MODE_BITS   (2),
        .DEFAULT_MODE(0),
        .LONG_CYCLES (24'd16),
        .BLINK_HALF  (24'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pb_debounced(pb_debounced),
        .mode        (mode),
        .mode_chg    (mode_chg),
        .long_press  (long_press),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_chg   = 0;
        cnt_long  = 0;
        cnt_led   = 0;
        cnt_blink = 0;
        led_prev  = led;
    endtask

    // Advance n cycles, sampling outputs 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (mode_chg)   cnt_chg++;
            if (long_press) cnt_long++;
            if (led)        cnt_led++;
            if (led && !led_prev) cnt_blink++;
            led_prev = led;
        end
    endtask

    // Hold the button low for n sampled cycles, release, and stop on the
    // sample where a short press shows its mode_chg pulse.
    task automatic press(input int n);
        pb_debounced = 1'b0;
        step(n);
        pb_debounced = 1'b1;
        step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        rst          = 1'b1;
        pb_debounced = 1'b1;
        #1;
        chk("rst_mode", 32'(mode), 0);
        chk("rst_chg",  32'(mode_chg), 0);
        chk("rst_long", 32'(long_press), 0);
        chk("rst_led",  32'(led), 0);
        step(2);
        rst = 1'b0;

        // 1: idle button
        clear_counts();
        step(20);
        chk("t1_mode", 32'(mode), 0);
        chk("t1_chg",  cnt_chg, 0);
        chk("t1_long", cnt_long, 0);
        chk("t1_led",  cnt_led, 0);

        // 2: single short press, two blinks
        clear_counts();
        press(5);
        chk("t2_chg_pulse", 32'(mode_chg), 1);
        chk("t2_mode", 32'(mode), 1);
        step(1);
        chk("t2_led_on", 32'(led), 1);
        step(30);
        chk("t2_chg_cnt", cnt_chg, 1);
        chk("t2_led_cycles", cnt_led, 8);
        chk("t2_blinks", cnt_blink, 2);
        chk("t2_led_end", 32'(led), 0);
        chk("t2_long", cnt_long, 0);

        // 3: wrap-around
        do_reset();
        clear_counts();
        press(3);
        chk("t3_mode_a", 32'(mode), 1);
        step(2);
        press(3);
        chk("t3_mode_b", 32'(mode), 2);
        step(2);
        press(3);
        chk("t3_mode_c", 32'(mode), 0);
        chk("t3_chg_cnt", cnt_chg, 3);

        // 4: long press from mode 2
        step(2);
        press(3);
        step(2);
        press(3);
        step(2);
        chk("t4_pre_mode", 32'(mode), 2);
        clear_counts();
        long_at = 0;
        chg_at  = 0;
        pb_debounced = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (long_press && long_at == 0) long_at = i;
            if (mode_chg && chg_at == 0)    chg_at  = i;
        end
        pb_debounced = 1'b1;
        step(10);
        chk("t4_long_at", long_at, 17);
        chk("t4_chg_at", chg_at, 17);
        chk("t4_mode", 32'(mode), 0);
        chk("t4_long_cnt", cnt_long, 1);
        chk("t4_chg_cnt", cnt_chg, 1);

        // boundary: release on the threshold cycle is short; one more is long
        step(2);
        clear_counts();
        press(16);
        chk("bnd_short_mode", 32'(mode), 1);
        chk("bnd_short_long", cnt_long, 0);
        step(2);
        clear_counts();
        press(17);
        step(2);
        chk("bnd_long_cnt", cnt_long, 1);
        chk("bnd_long_mode", 32'(mode), 0);

        // 5: button held through reset release
        step(2);
        pb_debounced = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        clear_counts();
        step(20);
        pb_debounced = 1'b1;
        step(10);
        chk("t5_mode", 32'(mode), 0);
        chk("t5_chg", cnt_chg, 0);
        chk("t5_long", cnt_long, 0);
        chk("t5_led", cnt_led, 0);
        press(3);
        chk("t5_after_mode", 32'(mode), 1);
        step(30);

        // 6: restart mid-sequence, then reset mid-blink
        press(3);
        chk("t6_mode_a", 32'(mode), 2);
        clear_counts();
        step(6);
        press(3);
        chk("t6_mode_b", 32'(mode), 0);
        step(20);
        chk("t6_led_cycles", cnt_led, 10);
        chk("t6_chg_cnt", cnt_chg, 1);
        chk("t6_led_end", 32'(led), 0);

        press(3);
        step(2);
        chk("t6_led_before_rst", 32'(led), 1);
        rst = 1'b1;
        #1;
        chk("t6_led_rst", 32'(led), 0);
        chk("t6_mode_rst", 32'(mode), 0);
        step(2);
        rst = 1'b0;
        step(5);
        chk("t6_led_after", 32'(led), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
